// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: sequencer state enum, register-index and wait-counter widths,
// and the x0 register index.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned WAIT_CNT_W = 8;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1
  } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use compare between the ID source registers and the EX
// destination register.
// Ports:
//   rs1, rs2          source register indices of the instruction in ID
//   uses_rs1/uses_rs2 ID instruction actually reads the source
//   rd                destination register of the instruction in EX
//   rd_load           EX instruction is a load
//   hit               ID must wait one cycle for the load result
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 uses_rs1,
  input  logic                 uses_rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 rd_load,
  output logic                 hit
);

  logic match_rs1;
  logic match_rs2;

  assign match_rs1 = uses_rs1 && (rs1 == rd);
  assign match_rs2 = uses_rs2 && (rs2 == rd);
  assign hit       = rd_load && (rd != X0_IDX) && (match_rs1 || match_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority each cycle: data-memory freeze > EX redirect > load-use.
// Stall/flush outputs are decoded combinationally from the current state and
// inputs; state, bubble counter, wait counter and timeout flag are registered.
// All outputs read 0 while rst is high.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs*   ID source operands
//   ex_rd/ex_memread            EX destination and load flag
//   ex_redirect                 taken branch/jump resolved in EX
//   mem_req/mem_ready           data-memory handshake
//   pc_stall .. memwb_flush     pipeline hold/flush controls
//   mem_timeout                 sticky memory-wait timeout flag
// Optional: define HAZ_PERF_CNT_EN to add stall_cycles/flush_events counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memread,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_stall,
  output logic                 idex_flush,
  output logic                 exmem_stall,
  output logic                 memwb_flush,
  output logic                 mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
`endif
);

  localparam int unsigned BUB_W = 3;
  localparam logic [BUB_W-1:0]      BUB_RELOAD  = BUB_W'(REDIRECT_BUBBLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX    = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST   = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [BUB_W-1:0]        bub_q, bub_d;
  logic [WAIT_CNT_W-1:0]   wait_q;
  logic                    timeout_q;

  logic freeze;
  logic load_use;
  logic timeout_set;

  assign freeze = mem_req && !mem_ready;

  hazard_cmp u_cmp (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .rd       (ex_rd),
    .rd_load  (ex_memread),
    .hit      (load_use)
  );

  // State, bubble counter and memory-wait tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      bub_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (freeze) begin
        if (wait_q != WAIT_MAX) wait_q <= wait_q + WAIT_CNT_W'(1);
      end else begin
        wait_q <= '0;
      end
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  // The flag is visible in the same cycle the final wait cycle is reached.
  assign timeout_set = freeze && (wait_q == WAIT_LAST);
  assign mem_timeout = !rst && (timeout_q || timeout_set);

  // Next-state and stall/flush decode.
  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;

    if (!rst) begin
      if (freeze) begin
        // Everything upstream of MEM holds; pending redirect/load-use persist
        // in the held stages and are acted on in the release cycle.
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else begin
        case (state_q)
          REDIR: begin
            ifid_flush = 1'b1;
            if (bub_q == BUB_W'(1)) begin
              state_d = RUN;
              bub_d   = '0;
            end else begin
              bub_d   = bub_q - BUB_W'(1);
            end
          end
          RUN: ;
          default: begin
            state_d = RUN;
            bub_d   = '0;
          end
        endcase

        if (ex_redirect) begin
          // Wrong-path ID instruction: any load-use against it is moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            state_d = REDIR;
            bub_d   = BUB_RELOAD;
          end
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall)   stall_cycles <= stall_cycles + 32'd1;
      if (idex_flush) flush_events <= flush_events + 32'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=3,
// MEM_TIMEOUT=8). Output vector bit order:
// {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
//  memwb_flush, mem_timeout}
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_redirect;
  logic       mem_req, mem_ready;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, memwb_flush, mem_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_RD   = 8'b0010_1000;
  localparam logic [7:0] O_BUB  = 8'b0010_0000;
  localparam logic [7:0] O_FRZ  = 8'b1101_0110;
  localparam logic [7:0] O_TO   = 8'b0000_0001;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REDIRECT_BUBBLES (3),
    .MEM_TIMEOUT      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_stall  (idex_stall),
    .idex_flush  (idex_flush),
    .exmem_stall (exmem_stall),
    .memwb_flush (memwb_flush),
    .mem_timeout (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, memwb_flush, mem_timeout};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance to 2 time units after the next rising edge (drive point).
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    mem_req = 1'b1;            // freeze condition must be masked by reset
    #2 chk("reset_masks_freeze", O_IDLE);
    cyc(); chk("reset_held", O_IDLE);
    cyc(); clr(); rst = 1'b0;
    #2 chk("run_idle", O_IDLE);
`ifdef HAZ_PERF_CNT_EN
    vectors++;
    assert (stall_cycles === 32'd0 && flush_events === 32'd0) else begin
      miscompares++;
      $error("FAIL perf_reset: observed %0d/%0d expected 0/0", stall_cycles, flush_events);
    end
`endif

    // Load-use on rs2, then one clean cycle.
    cyc(); ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #2 chk("load_use_rs2", O_LU);
    cyc(); clr(); #2 chk("load_use_one_cycle", O_IDLE);

    // Load-use on rs1; same match but operand unused; match without load.
    cyc(); ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #2 chk("load_use_rs1", O_LU);
    cyc(); id_uses_rs1 = 1'b0; #2 chk("rs1_unused", O_IDLE);
    cyc(); id_uses_rs1 = 1'b1; ex_memread = 1'b0; #2 chk("no_load", O_IDLE);

    // Load to x0 never stalls.
    cyc(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #2 chk("x0_load", O_IDLE);

    // Redirect pulse with a simultaneous load-use: three IF/ID bubbles.
    cyc(); clr(); ex_redirect = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #2 chk("redirect_first", O_RD);
    cyc(); clr(); #2 chk("redirect_bub2", O_BUB);
    cyc(); #2 chk("redirect_bub3", O_BUB);
    cyc(); #2 chk("redirect_back_run", O_IDLE);

    // Freeze for 4 cycles with redirect held, then release.
    cyc(); mem_req = 1'b1; ex_redirect = 1'b1;
    #2 chk("freeze_1", O_FRZ);
    for (int i = 2; i <= 4; i++) begin
      cyc(); #2 chk($sformatf("freeze_%0d", i), O_FRZ);
    end
    cyc(); mem_ready = 1'b1; #2 chk("freeze_release", O_RD);
    cyc(); clr(); #2 chk("release_bub2", O_BUB);
    cyc(); #2 chk("release_bub3", O_BUB);
    cyc(); #2 chk("release_run", O_IDLE);

    // Freeze inside REDIR holds the bubble count; load-use acts during REDIR.
    cyc(); ex_redirect = 1'b1; #2 chk("redir2_first", O_RD);
    cyc(); clr(); mem_req = 1'b1; #2 chk("redir_freeze", O_FRZ);
    cyc(); clr(); ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    #2 chk("redir_load_use", O_BUB | O_LU);
    cyc(); clr(); #2 chk("redir_bub_last", O_BUB);
    cyc(); #2 chk("redir_freeze_run", O_IDLE);

    // Second redirect while in REDIR reloads the bubble count.
    cyc(); ex_redirect = 1'b1; #2 chk("rr_first", O_RD);
    cyc(); #2 chk("rr_reload", O_RD);
    cyc(); clr(); #2 chk("rr_bub2", O_BUB);
    cyc(); #2 chk("rr_bub3", O_BUB);
    cyc(); #2 chk("rr_run", O_IDLE);

    // Timeout: flag rises in freeze cycle 8 and is sticky.
    cyc(); mem_req = 1'b1;
    #2 chk("to_freeze_1", O_FRZ);
    for (int i = 2; i <= 10; i++) begin
      cyc();
      #2 chk($sformatf("to_freeze_%0d", i), (i >= 8) ? (O_FRZ | O_TO) : O_FRZ);
    end
    cyc(); clr(); mem_ready = 1'b1; #2 chk("to_sticky_1", O_TO);
    cyc(); clr(); #2 chk("to_sticky_2", O_TO);

    // Async reset in REDIR with bub_cnt=2: outputs clear with no clock edge.
    cyc(); ex_redirect = 1'b1; #2 chk("rst_redir_first", O_RD | O_TO);
    cyc(); clr(); #1 chk("rst_redir_bub", O_BUB | O_TO);
    #1 rst = 1'b1;
    #1 chk("async_rst_immediate", O_IDLE);
    cyc(); rst = 1'b0; #2 chk("post_rst_no_flush", O_IDLE);
    cyc(); #2 chk("post_rst_idle", O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards between ID and EX.
- Applies branch/jump redirect flushes, with extra IF/ID bubbles for multi-cycle instruction memory.
- Freezes the whole pipeline while data memory is not ready.
- Drives the ID/EX flush and hold inputs, the IF/ID flush and hold inputs, and the PC hold.

Parameters:
REDIRECT_BUBBLES, 1, number of cycles IF/ID is flushed after a redirect (1..7).
MEM_TIMEOUT, 64, memory-wait cycle count at which mem_timeout is raised (2..255).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
id_rs1  in  5  rs1 index of the instruction in ID.
id_rs2  in  5  rs2 index of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_rd  in  5  destination register of the instruction in EX.
ex_memread  in  1  EX instruction is a load.
ex_redirect  in  1  EX resolved a taken branch or jump.
mem_req  in  1  MEM stage has an active data access.
mem_ready  in  1  data memory completes the access this cycle.
pc_stall  out  1  hold PC.
ifid_stall  out  1  hold IF/ID.
ifid_flush  out  1  zero IF/ID.
idex_stall  out  1  hold ID/EX.
idex_flush  out  1  zero ID/EX (bubble).
exmem_stall  out  1  hold EX/MEM.
memwb_flush  out  1  insert bubble into MEM/WB.
mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset:
  - Asynchronous; state=RUN, bub_cnt=0, wait_cnt=0, mem_timeout=0.
  - All outputs are 0 while rst=1.
  - Reset asserted mid-wait or mid-redirect abandons the operation immediately.
- Output decode: all stall/flush outputs are combinational from the current state and inputs (zero-latency, Mealy). The state and counters are registered.
- Conditions:
  - freeze = mem_req & ~mem_ready.
  - load_use = ex_memread & (ex_rd != 0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority per cycle: freeze > redirect > load_use.
- freeze:
  - Outputs: pc_stall = ifid_stall = idex_stall = exmem_stall = memwb_flush = 1. All flushes are suppressed.
  - Any redirect or load_use in the same cycle is ignored. Both persist because the stages are held, and they are acted on in the release cycle.
  - bub_cnt is held.
- Redirect (no freeze, ex_redirect=1):
  - Outputs: ifid_flush = idex_flush = 1; pc_stall = 0 so the PC loads the target.
  - load_use in the same cycle is discarded because the ID instruction is wrong-path.
  - If REDIRECT_BUBBLES > 1: next state=REDIR, bub_cnt = REDIRECT_BUBBLES-1.
- load_use (no freeze, no redirect):
  - Outputs: pc_stall = ifid_stall = idex_flush = 1 for exactly one cycle.
- States:
  - RUN: rules above apply.
  - REDIR:
    - Without freeze: ifid_flush=1 and bub_cnt decrements; when bub_cnt reaches 1, next state=RUN.
    - A new ex_redirect reloads bub_cnt = REDIRECT_BUBBLES-1 and asserts idex_flush.
    - load_use is evaluated normally.
    - freeze holds the state and the counter.
- Memory-wait counter:
  - wait_cnt is 8 bits; it increments each freeze cycle and saturates at MEM_TIMEOUT.
  - It clears to 0 on any non-freeze cycle.
  - mem_timeout sets when wait_cnt == MEM_TIMEOUT-1 and freeze=1, and stays set until rst.
- ex_rd=0 never causes a stall.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0 and wrapping modulo 2^32.
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_events increments on every cycle with idex_flush=1.
- Undefined: these ports and the counter logic are absent.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum RUN=0, REDIR=1 (2-bit encoding);
  - REG_IDX_W=5;
  - WAIT_CNT_W=8;
  - the x0 constant.
- Sub-module hazard_cmp (combinational load-use compare, reused by a future forwarding unit) is natural.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=ifid_stall=idex_flush=1 for one cycle, all 0 next cycle.
- x0 load: ex_memread=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 -> no stall.
- Redirect with REDIRECT_BUBBLES=3: ex_redirect pulse -> ifid_flush=1 for 3 consecutive cycles; idex_flush=1 only in the first; state returns to RUN.
- Freeze: mem_req=1, mem_ready=0 for 4 cycles, with ex_redirect=1 held throughout -> 4 cycles of all holds plus memwb_flush and no flushes; release cycle asserts ifid_flush=idex_flush=1.
- Timeout with MEM_TIMEOUT=8: 10 freeze cycles -> mem_timeout rises in the 8th cycle and stays 1 after mem_ready returns, until rst.
- Async rst mid-REDIR (bub_cnt=2) -> all outputs 0 immediately, with no clock edge needed; after rst deassertion, no residual ifid_flush.
